// File: rtl/prrty_resolver_n.sv
// Priority resolver for the PIC core: IRR/ISR, mask, fixed/rotating priority, INTA sequencing, EOI/AEOI.
// Optional special-mask mode is compiled in with `define PRRTY_SMM_EN (adds the smm input).
module prrty_resolver_n #(
    parameter int NCH      = 8,
    parameter bit LVL_TRIG = 1'b0,
    localparam int IW      = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] ir,
    input  logic [NCH-1:0] imr,
    input  logic           fn,
    input  logic           ar,
    input  logic           aeoi,
    input  logic           eoi,
    input  logic           seoi,
    input  logic [IW-1:0]  eoi_lvl,
    input  logic           set_prio,
    input  logic           inta,
`ifdef PRRTY_SMM_EN
    input  logic           smm,
`endif
    output logic           int_out,
    output logic [NCH-1:0] irr,
    output logic [NCH-1:0] isr,
    output logic [IW-1:0]  vec_id,
    output logic           vec_vld,
    output logic           dbg_state,
    output logic [IW-1:0]  dbg_lp
);

    // Handshake: inta is a one-clock strobe per bus cycle; no back-pressure.
    // vec_vld is a one-clock strobe, registered off the second inta, with vec_id stable.

    typedef enum logic {IDLE = 1'b0, ACK1 = 1'b1} state_t;

    state_t         state, state_nx;
    logic [IW-1:0]  lp, lp_nx;
    logic [NCH-1:0] ir_q;
    logic           spur;

    logic [NCH-1:0] pend, isr_blk, irr_nx, isr_nx, isr_set, isr_clr;
    logic [IW:0]    p_pick, b_pick, e_pick;
    logic           int_req, lvl_ok, ack0, ack1;

    // Highest-priority set bit of v when lowest priority is base: {found, channel}.
    function automatic logic [IW:0] pick(input logic [NCH-1:0] v, input logic [IW-1:0] base);
        logic [IW:0] res;
        int          idx;
        res = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = (int'(base) + 1 + k) % NCH;
            if (v[idx]) res = {1'b1, IW'(idx)};
        end
        return res;
    endfunction

    // 0 is the highest rank, NCH-1 the lowest.
    function automatic int rank_of(input logic [IW-1:0] ch, input logic [IW-1:0] base);
        return (int'(ch) - int'(base) - 1 + 2 * NCH) % NCH;
    endfunction

    always_comb begin
        pend = irr & ~imr;
`ifdef PRRTY_SMM_EN
        isr_blk = smm ? (isr & ~imr) : isr;
`else
        isr_blk = isr;
`endif
        p_pick = pick(pend, lp);
        b_pick = pick(isr_blk, lp);
        e_pick = pick(isr, lp);

        int_req = 1'b0;
        if (p_pick[IW]) begin
            if (!b_pick[IW])
                int_req = 1'b1;
            else if (rank_of(p_pick[IW-1:0], lp) < rank_of(b_pick[IW-1:0], lp))
                int_req = 1'b1;
            else if (fn && (p_pick[IW-1:0] == b_pick[IW-1:0]))
                int_req = 1'b1;
        end

        lvl_ok = int'(eoi_lvl) < NCH;
        ack0   = (state == IDLE) && inta;
        ack1   = (state == ACK1) && inta;

        isr_set = '0;
        if (ack0 && p_pick[IW]) isr_set[p_pick[IW-1:0]] = 1'b1;

        isr_clr = '0;
        if (eoi && e_pick[IW])            isr_clr[e_pick[IW-1:0]] = 1'b1;
        if (seoi && lvl_ok)               isr_clr[eoi_lvl]        = 1'b1;
        if (ack1 && aeoi && !spur)        isr_clr[vec_id]         = 1'b1;

        // A clear always beats a set on the same bit.
        isr_nx = (isr | isr_set) & ~isr_clr;

        if (LVL_TRIG)
            irr_nx = ir;
        else
            irr_nx = (irr & ~isr_set) | (ir & ~ir_q);

        lp_nx = lp;
        if (set_prio && lvl_ok)
            lp_nx = eoi_lvl;
        else if (seoi && lvl_ok && ar)
            lp_nx = eoi_lvl;
        else if (eoi && e_pick[IW] && ar)
            lp_nx = e_pick[IW-1:0];
        else if (ack1 && aeoi && !spur && ar)
            lp_nx = vec_id;

        state_nx = state;
        if (ack0)      state_nx = ACK1;
        else if (ack1) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            lp      <= IW'(NCH - 1);
            ir_q    <= '0;
            irr     <= '0;
            isr     <= '0;
            int_out <= 1'b0;
            vec_id  <= '0;
            vec_vld <= 1'b0;
            spur    <= 1'b0;
        end else begin
            state   <= state_nx;
            lp      <= lp_nx;
            ir_q    <= ir;
            irr     <= irr_nx;
            isr     <= isr_nx;
            int_out <= (state_nx == IDLE) && int_req;
            vec_vld <= ack1;
            if (ack0) begin
                spur   <= !p_pick[IW];
                vec_id <= p_pick[IW] ? p_pick[IW-1:0] : IW'(NCH - 1);
            end
        end
    end

    assign dbg_state = state;
    assign dbg_lp    = lp;

endmodule

// File: tb/tb_prrty_resolver_n.sv
// Self-checking bench for prrty_resolver_n (NCH=8, edge-triggered): vec_id scoreboard plus directed register checks.
module tb_prrty_resolver_n;

    localparam int NCH = 8;
    localparam int IW  = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] ir, imr;
    logic           fn, ar, aeoi, eoi, seoi, set_prio, inta;
    logic [IW-1:0]  eoi_lvl;
    logic           int_out, vec_vld, dbg_state;
    logic [NCH-1:0] irr, isr;
    logic [IW-1:0]  vec_id, dbg_lp;
`ifdef PRRTY_SMM_EN
    logic           smm = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    logic [IW-1:0] exp_q[$];

    prrty_resolver_n #(.NCH(NCH), .LVL_TRIG(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .imr(imr), .fn(fn), .ar(ar), .aeoi(aeoi),
        .eoi(eoi), .seoi(seoi), .eoi_lvl(eoi_lvl), .set_prio(set_prio), .inta(inta),
`ifdef PRRTY_SMM_EN
        .smm(smm),
`endif
        .int_out(int_out), .irr(irr), .isr(isr), .vec_id(vec_id), .vec_vld(vec_vld),
        .dbg_state(dbg_state), .dbg_lp(dbg_lp)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ir = '0; imr = '0; fn = 0; ar = 0; aeoi = 0;
        eoi = 0; seoi = 0; set_prio = 0; inta = 0; eoi_lvl = '0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic inta_pulse();
        inta = 1'b1; tick();
        inta = 1'b0; tick();
    endtask

    task automatic serve(input logic [IW-1:0] exp_vec);
        inta_pulse();
        exp_q.push_back(exp_vec);
        inta_pulse();
    endtask

    // scoreboard: every vec_vld must match the oldest expected vector
    always @(negedge clk) begin
        if (rst_n && vec_vld) begin
            if (exp_q.size() == 0) check("sb_unexpected", 1, 0);
            else check("sb_vec", vec_id, exp_q.pop_front());
        end
    end

    initial begin
        // 1: reset values, basic two-INTA acknowledge
        do_reset();
        check("rst_irr", irr, 0);
        check("rst_isr", isr, 0);
        check("rst_int", int_out, 0);
        check("rst_vec", vec_id, 0);
        check("rst_vld", vec_vld, 0);
        check("rst_lp", dbg_lp, 7);
        check("rst_state", dbg_state, 0);
        ir = 8'h0A; tick();
        check("t1_irr", irr, 8'h0A);
        tick();
        check("t1_int", int_out, 1);
        inta = 1'b1; tick();
        check("t1_state_ack1", dbg_state, 1);
        check("t1_int_ack1", int_out, 0);
        check("t1_vec", vec_id, 1);
        check("t1_isr", isr, 8'h02);
        check("t1_irr_ack", irr, 8'h08);
        inta = 1'b0; tick();
        exp_q.push_back(3'd1);
        inta = 1'b1; tick();
        check("t1_vld", vec_vld, 1);
        check("t1_state_idle", dbg_state, 0);
        inta = 1'b0; tick();
        check("t1_vld_off", vec_vld, 0);

        // 2: lower level blocked, fn allows same level, higher level interrupts
        check("t2_lower", int_out, 0);
        ir = 8'h08; tick();
        ir = 8'h0A; tick();
        check("t2_irr", irr, 8'h0A);
        tick();
        check("t2_fn0_equal", int_out, 0);
        fn = 1'b1; tick();
        check("t2_fn1_equal", int_out, 1);
        fn = 1'b0; tick();
        ir = 8'h0B; tick(); tick();
        check("t2_higher", int_out, 1);

        // 3: rotating priority with AEOI
        do_reset();
        ar = 1'b1; aeoi = 1'b1;
        ir = 8'h04; tick(); tick();
        serve(3'd2);
        check("t3_isr", isr, 0);
        check("t3_lp", dbg_lp, 2);
        ir = 8'h00; tick();
        ir = 8'h06; tick();
        check("t3_irr", irr, 8'h06);
        serve(3'd1);
        check("t3_lp2", dbg_lp, 1);
        check("t3_irr2", irr, 8'h04);
        check("t3_isr2", isr, 0);

        // 4: spurious acknowledge
        do_reset();
        ir = 8'h01; tick();
        imr = 8'hFF;
        inta_pulse();
        check("t4_vec", vec_id, 7);
        check("t4_isr", isr, 0);
        check("t4_irr", irr, 8'h01);
        exp_q.push_back(3'd7);
        inta = 1'b1; tick();
        check("t4_vld", vec_vld, 1);
        inta = 1'b0; tick();
        check("t4_isr_end", isr, 0);

        // 5: eoi + seoi same clock, then set_prio, then eoi with empty isr
        do_reset();
        ar = 1'b1;
        ir = 8'h21; tick();
        serve(3'd0);
        serve(3'd5);
        check("t5_isr_pre", isr, 8'h21);
        eoi = 1'b1; seoi = 1'b1; eoi_lvl = 3'd5; tick();
        eoi = 1'b0; seoi = 1'b0;
        check("t5_isr", isr, 0);
        check("t5_lp", dbg_lp, 5);
        set_prio = 1'b1; eoi_lvl = 3'd3; tick();
        set_prio = 1'b0;
        check("t5_setprio", dbg_lp, 3);
        eoi = 1'b1; tick();
        eoi = 1'b0;
        check("t5_eoi_noop", dbg_lp, 3);

        // 6: reset during ACK1 aborts, then a fresh sequence starts from IDLE
        do_reset();
        ir = 8'h01; tick(); tick();
        inta_pulse();
        check("t6_ack1", dbg_state, 1);
        rst_n = 1'b0; tick();
        check("t6_rst_state", dbg_state, 0);
        check("t6_rst_isr", isr, 0);
        check("t6_rst_irr", irr, 0);
        check("t6_rst_int", int_out, 0);
        check("t6_rst_vec", vec_id, 0);
        rst_n = 1'b1; tick();
        check("t6_irr", irr, 8'h01);
        tick();
        check("t6_int", int_out, 1);
        inta = 1'b1; tick();
        check("t6_restart", dbg_state, 1);
        check("t6_isr", isr, 8'h01);
        inta = 1'b0; tick();
        exp_q.push_back(3'd0);
        inta_pulse();

        tick();
        check("sb_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
